// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage controller for a data memory with variable latency.
// Runs an IDLE -> WAIT -> DONE handshake with the memory, stalls the upstream
// pipeline while an access is in flight, abandons an access after TIMEOUT WAIT
// cycles, and drives the MEM/WB pipeline register.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned accesses
// (no memory request, one-cycle misalign_o pulse, register write suppressed).
module mem_stage_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] ALUres_i,
  input  logic [31:0] wrdata_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] ALUres_o,
  output logic [31:0] rddata_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic        err_o,
  output logic        misalign_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        req_q, req_d;
  logic        err_q, err_d;
  logic        mis_q, mis_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] rd_q, rd_d;
  logic        rw_q, rw_d;
  logic        m2r_q, m2r_d;

  logic access;
  logic misaligned;

  assign access     = MemRead_i | MemWrite_i;
  // With the check compiled out, the low address bits never matter.
  assign misaligned = ALIGN_CHK && (ALUres_i[1:0] != 2'b00);

  // Stall upstream while an access is being launched or is in flight.
  always_comb begin
    stall_o = 1'b0;
    if (!rst_i)
      stall_o = ((state_q == S_IDLE) && access) || (state_q == S_WAIT);
  end

  // Next-state, memory handshake and MEM/WB load selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    req_d   = req_q;
    err_d   = err_q;
    mis_d   = 1'b0;
    // Bubble unless a non-stalling cycle overrides it below.
    alu_d   = 32'h0;
    rd_d    = 32'h0;
    rw_d    = 1'b0;
    m2r_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          addr_d  = {ALUres_i[31:2], 2'b00};
          wdata_d = wrdata_i;
          we_d    = MemWrite_i;      // read+write together is treated as a write
          buf_d   = 32'h0;
          cnt_d   = 8'h0;
          mis_d   = misaligned;
          req_d   = !misaligned;
          state_d = misaligned ? S_DONE : S_WAIT;
        end else begin
          alu_d = ALUres_i;
          rw_d  = RegWrite_i;
          m2r_d = MemtoReg_i;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'h1;
        if (mem_ack_i) begin
          // Ack beats a coincident timeout and leaves err untouched.
          if (!we_q) buf_d = mem_rdata_i;
          cnt_d   = 8'h0;
          req_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          buf_d   = 32'hDEAD_BEEF;
          err_d   = 1'b1;
          cnt_d   = 8'h0;
          req_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        alu_d   = ALUres_i;
        rd_d    = we_q ? 32'h0 : buf_q;
        rw_d    = RegWrite_i & ~mis_q;
        m2r_d   = MemtoReg_i;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'h0;
      buf_q   <= 32'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      alu_q   <= 32'h0;
      rd_q    <= 32'h0;
      rw_q    <= 1'b0;
      m2r_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      req_q   <= req_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      m2r_q   <= m2r_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign ALUres_o    = alu_q;
  assign rddata_o    = rd_q;
  assign RegWrite_o  = rw_q;
  assign MemtoReg_o  = m2r_q;
  assign err_o       = err_q;
  assign misalign_o  = mis_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed scoreboard bench for mem_stage_ctrl.
// The driver acts as EX/MEM stage and data memory; each issued instruction
// pushes its expected MEM/WB contents, and a monitor pops and compares them
// after the edge at which the instruction leaves the MEM stage.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] ALUres_i = '0, wrdata_i = '0, mem_rdata_i = '0;
  logic        MemRead_i = 0, MemWrite_i = 0, RegWrite_i = 0, MemtoReg_i = 0;
  logic        mem_ack_i = 0;
  logic        stall_o, mem_req_o, mem_we_o, RegWrite_o, MemtoReg_o, err_o, misalign_o;
  logic [31:0] mem_addr_o, mem_wdata_o, ALUres_o, rddata_o;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .ALUres_i(ALUres_i), .wrdata_i(wrdata_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .RegWrite_i(RegWrite_i),
    .MemtoReg_i(MemtoReg_i), .stall_o(stall_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .ALUres_o(ALUres_o),
    .rddata_o(rddata_o), .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
    .err_o(err_o), .misalign_o(misalign_o)
  );

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] rd;
    logic        rw;
    logic        m2r;
  } wb_t;

  wb_t sb[$];
  int  checks = 0;
  int  errors = 0;
  bit  ins_vld = 1'b0;
  bit  commit_pend = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // A real instruction that sees no stall leaves the stage at the next edge.
  always begin
    @(negedge clk);
    #1;
    commit_pend = ins_vld && !stall_o && !rst_i;
  end

  // Monitor: compare MEM/WB contents right after a committing edge.
  always begin
    bit  cm;
    wb_t e;
    @(posedge clk);
    cm = commit_pend;
    #1;
    if (cm) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'h1, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("wb_alu", ALUres_o, e.alu);
        chk("wb_rd", rddata_o, e.rd);
        chk("wb_rw", {31'h0, RegWrite_o}, {31'h0, e.rw});
        chk("wb_m2r", {31'h0, MemtoReg_o}, {31'h0, e.m2r});
      end
    end
  end

  // Issue one instruction and play memory: ack in WAIT cycle ack_after (0 = never).
  task automatic issue(input logic [31:0] alu, input logic [31:0] wd,
                       input bit rd, input bit wr, input bit rw, input bit m2r,
                       input int ack_after, input logic [31:0] rdata, input wb_t exp,
                       output int stalls, output int reqs, output int mis,
                       output logic [31:0] a_addr, output logic [31:0] a_wdata,
                       output logic a_we);
    bit done = 1'b0;
    stalls = 0; reqs = 0; mis = 0;
    a_addr = '0; a_wdata = '0; a_we = 1'b0;
    @(negedge clk);
    ALUres_i = alu; wrdata_i = wd; MemRead_i = rd; MemWrite_i = wr;
    RegWrite_i = rw; MemtoReg_i = m2r; ins_vld = 1'b1;
    sb.push_back(exp);
    for (int c = 0; c < 64 && !done; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (stall_o) stalls++;
      if (misalign_o) mis++;
      if (mem_req_o) begin
        reqs++;
        if (reqs == 1) begin
          a_addr = mem_addr_o; a_wdata = mem_wdata_o; a_we = mem_we_o;
        end
        mem_ack_i   = (reqs == ack_after);
        mem_rdata_i = mem_ack_i ? rdata : 32'h5555_AAAA;
      end else begin
        mem_ack_i = 1'b0;
      end
      if (!stall_o) done = 1'b1;
    end
    if (!done) chk("cycle_budget", 32'h0, 32'h1);
    @(negedge clk);
    ALUres_i = '0; wrdata_i = '0; MemRead_i = 0; MemWrite_i = 0;
    RegWrite_i = 0; MemtoReg_i = 0; ins_vld = 1'b0; mem_ack_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_alu"}, ALUres_o, 32'h0);
    chk({nm, "_rd"}, rddata_o, 32'h0);
    chk({nm, "_flags"}, {24'h0, stall_o, mem_req_o, mem_we_o, RegWrite_o,
                         MemtoReg_o, err_o, misalign_o, 1'b0}, 32'h0);
    chk({nm, "_addr"}, mem_addr_o, 32'h0);
    chk({nm, "_wdata"}, mem_wdata_o, 32'h0);
  endtask

  initial begin
    int st, rq, ms;
    logic [31:0] ad, wdat;
    logic we;

    // Reset with a pending read on the inputs: no stall while in reset.
    MemRead_i = 1'b1; ALUres_i = 32'h100;
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    MemRead_i = 1'b0; ALUres_i = '0;
    @(negedge clk);
    rst_i = 1'b0;

    // Non-memory op.
    issue(32'h7, 32'h0, 0, 0, 1, 0, 0, 32'h0, '{32'h7, 32'h0, 1'b1, 1'b0},
          st, rq, ms, ad, wdat, we);
    chk("nop_stalls", st, 0);
    chk("nop_reqs", rq, 0);

    // Load, ack in first WAIT cycle.
    issue(32'h100, 32'h0, 1, 0, 1, 1, 1, 32'hCAFE_0001,
          '{32'h100, 32'hCAFE_0001, 1'b1, 1'b1}, st, rq, ms, ad, wdat, we);
    chk("ld_stalls", st, 2);
    chk("ld_reqs", rq, 1);
    chk("ld_addr", ad, 32'h100);
    chk("ld_we", {31'h0, we}, 32'h0);

    // Store, ack after 4 WAIT cycles.
    issue(32'h204, 32'h1234_5678, 0, 1, 0, 0, 4, 32'hFFFF_FFFF,
          '{32'h204, 32'h0, 1'b0, 1'b0}, st, rq, ms, ad, wdat, we);
    chk("st_stalls", st, 5);
    chk("st_reqs", rq, 4);
    chk("st_addr", ad, 32'h204);
    chk("st_wdata", wdat, 32'h1234_5678);
    chk("st_we", {31'h0, we}, 32'h1);

    // Read and write together behave as a write.
    issue(32'h30, 32'hA5A5_A5A5, 1, 1, 0, 0, 2, 32'h1111_1111,
          '{32'h30, 32'h0, 1'b0, 1'b0}, st, rq, ms, ad, wdat, we);
    chk("rw_we", {31'h0, we}, 32'h1);
    chk("rw_wdata", wdat, 32'hA5A5_A5A5);
    chk("rw_reqs", rq, 2);

    // Ack on the last allowed WAIT cycle wins over the timeout.
    issue(32'h40, 32'h0, 1, 0, 1, 1, 16, 32'h0BAD_F00D,
          '{32'h40, 32'h0BAD_F00D, 1'b1, 1'b1}, st, rq, ms, ad, wdat, we);
    chk("edge_reqs", rq, 16);
    chk("edge_err", {31'h0, err_o}, 32'h0);

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned read: no request, one misalign pulse, write-back suppressed.
    issue(32'h102, 32'h0, 1, 0, 1, 1, 1, 32'h77,
          '{32'h102, 32'h0, 1'b0, 1'b1}, st, rq, ms, ad, wdat, we);
    chk("mis_reqs", rq, 0);
    chk("mis_pulses", ms, 1);
    chk("mis_stalls", st, 1);
    #1 chk("mis_after", {31'h0, misalign_o}, 32'h0);
`else
    // Low address bits are ignored when the check is compiled out.
    issue(32'h102, 32'h0, 1, 0, 1, 1, 1, 32'h77,
          '{32'h102, 32'h77, 1'b1, 1'b1}, st, rq, ms, ad, wdat, we);
    chk("unal_addr", ad, 32'h100);
    chk("unal_mis", ms, 0);
`endif

    // Timeout: read with no ack.
    issue(32'h80, 32'h0, 1, 0, 1, 1, 0, 32'h0,
          '{32'h80, 32'hDEAD_BEEF, 1'b1, 1'b1}, st, rq, ms, ad, wdat, we);
    chk("to_reqs", rq, 16);
    chk("to_stalls", st, 17);
    chk("to_err", {31'h0, err_o}, 32'h1);
    repeat (3) @(negedge clk);
    #1 chk("err_sticky", {31'h0, err_o}, 32'h1);

    // Reset in the 2nd WAIT cycle, then a late ack.
    @(negedge clk);
    MemRead_i = 1'b1; ALUres_i = 32'h300; RegWrite_i = 1'b1; MemtoReg_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 chk("rst_wait2_req", {31'h0, mem_req_o}, 32'h1);
    rst_i = 1'b1;
    #1 chk("rst_stall", {31'h0, stall_o}, 32'h0);
    @(negedge clk);
    rst_i = 1'b0; MemRead_i = 1'b0; ALUres_i = '0; RegWrite_i = 1'b0;
    MemtoReg_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h99;
    #1 chk_all_zero("post_rst");
    @(negedge clk);
    mem_ack_i = 1'b0;
    #1 chk_all_zero("late_ack");

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 Parameter TIMEOUT, default 16, SHALL set the maximum number of WAIT cycles before an access is abandoned (range 1..255).
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous active-high reset
- ALUres_i  in  32  EX/MEM address / ALU result
- wrdata_i  in  32  EX/MEM store data
- MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i  in  1 each  EX/MEM control
- stall_o  out  1  holds PC, IF/ID, ID/EX and EX/MEM
- mem_req_o  out  1  data-memory request
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  32  word address
- mem_wdata_o  out  32  store data
- mem_ack_i  in  1  memory completion
- mem_rdata_i  in  32  load data, valid with mem_ack_i
- ALUres_o, rddata_o  out  32 each  MEM/WB register outputs
- RegWrite_o, MemtoReg_o  out  1 each  MEM/WB control
- err_o  out  1  sticky timeout flag
- misalign_o  out  1  one-cycle misalignment pulse (macro only)

Function
REQ-004 The FSM SHALL have states IDLE, WAIT and DONE.
REQ-005 In IDLE with MemRead_i=0 and MemWrite_i=0, stall_o SHALL be 0 and the MEM/WB outputs SHALL load ALUres_i, 0, RegWrite_i and MemtoReg_i at the next edge.
REQ-006 In IDLE with MemRead_i or MemWrite_i set, stall_o SHALL be 1 combinationally. At the edge the block SHALL go to WAIT and register the following: mem_addr_o={ALUres_i[31:2],2'b00}, mem_wdata_o=wrdata_i, mem_we_o=MemWrite_i.
REQ-007 If MemRead_i and MemWrite_i are both 1, the access SHALL be a write.
REQ-008 In WAIT, mem_req_o and stall_o SHALL be 1, and the 8-bit wait counter SHALL increment every cycle.
REQ-009 In WAIT with mem_ack_i=1, the block SHALL capture mem_rdata_i (reads) into a data buffer, clear the counter and go to DONE.
REQ-010 In WAIT, when the counter equals TIMEOUT-1 and mem_ack_i=0, the block SHALL set the buffer to 32'hDEADBEEF, set err_o, and go to DONE.
REQ-011 If ack and timeout occur in the same cycle, ack SHALL win and err_o SHALL be unchanged.
REQ-012 In DONE, stall_o SHALL be 0, and mem_req_o SHALL be 0.
REQ-013 At the DONE edge, the MEM/WB outputs SHALL load ALUres_i, the buffer (0 for writes), RegWrite_i and MemtoReg_i, and the FSM SHALL return to IDLE.
REQ-014 During every stall cycle, the MEM/WB outputs SHALL load a bubble: RegWrite_o=0, MemtoReg_o=0, ALUres_o=0, rddata_o=0.
REQ-015 Minimum access latency SHALL be 3 cycles (IDLE, WAIT with ack, DONE). An ack in the first WAIT cycle SHALL be accepted.
REQ-016 mem_ack_i SHALL be ignored outside WAIT.
REQ-017 err_o SHALL stay set until reset.

Reset
REQ-018 At a reset edge, the block SHALL enter IDLE and clear the counter, buffer, all MEM/WB outputs, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o and misalign_o to 0.
REQ-019 Reset asserted mid-access (WAIT or DONE) SHALL abandon the access with no MEM/WB update. A late mem_ack_i after reset SHALL be ignored.
REQ-020 stall_o SHALL be 0 while rst_i=1.

Configuration
REQ-021 With MEM_ALIGN_CHECK_EN defined, an IDLE access with ALUres_i[1:0]!=0 SHALL skip WAIT and go directly to DONE with mem_req_o never asserted. misalign_o SHALL pulse 1 in that DONE cycle, and the MEM/WB load SHALL force RegWrite_o=0.
REQ-022 With MEM_ALIGN_CHECK_EN undefined, ALUres_i[1:0] SHALL be ignored for addressing, and misalign_o SHALL be tied to 0.

Verification
REQ-023 Load: MemRead_i=1, ALUres_i=0x100, RegWrite_i=1, MemtoReg_i=1, ack in the 1st WAIT cycle with rdata=0xCAFE0001 -> stall_o=1,1,0, then rddata_o=0xCAFE0001 and RegWrite_o=1 one edge after DONE.
REQ-024 Store: MemWrite_i=1, ALUres_i=0x204, wrdata_i=0x12345678, ack after 4 WAIT cycles -> mem_we_o=1, mem_addr_o=0x204, mem_wdata_o=0x12345678, stall_o high for 5 cycles, rddata_o=0.
REQ-025 Timeout: TIMEOUT=16, read, no ack -> mem_req_o high exactly 16 cycles, then err_o=1 and rddata_o=0xDEADBEEF.
REQ-026 Non-memory op: ALUres_i=7, RegWrite_i=1 -> stall_o never asserted, and ALUres_o=7 one edge later.
REQ-027 Reset in the 2nd WAIT cycle, then ack the next cycle -> state IDLE, all outputs 0, no MEM/WB update.
REQ-028 With MEM_ALIGN_CHECK_EN defined: read with ALUres_i=0x102 -> mem_req_o stays 0, misalign_o pulses once, RegWrite_o=0.
